// File: rtl/i_cache_2way.sv
// i_cache_2way: two-way set-associative instruction cache with per-set LRU and single-line refill
module i_cache_2way #(
  parameter int ADDR_W = 15,
  parameter int LINE_W = 256,
  parameter int SETS   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ic_exp,
  input  logic              flush,
  output logic [LINE_W-1:0] r_data,
  output logic              ic_hit,
  output logic              ic_miss,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_data
);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, FILL = 2'd2;
  logic [1:0]        state;
  logic [TAG_W-1:0]  tag_mem [2][SETS];
  logic [LINE_W-1:0] data_mem [2][SETS];
  logic [SETS-1:0]   valid [2];
  logic [SETS-1:0]   lru;
  logic              discard;
  logic [TAG_W-1:0]  cap_tag;
  logic [IDX_W-1:0]  cap_idx;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [1:0]        way_hit;
  logic              hit, launch, fill, victim;
  assign idx = addr[OFF_W+IDX_W-1:OFF_W];
  assign tag = addr[ADDR_W-1:OFF_W+IDX_W];
  assign way_hit[0] = valid[0][idx] & (tag_mem[0][idx] == tag);
  assign way_hit[1] = valid[1][idx] & (tag_mem[1][idx] == tag);
  assign hit = ren & ~ic_exp & (state == IDLE) & ~flush & |way_hit;
  assign launch = (state == IDLE) & ren & ~ic_exp & ~flush & ~hit;
  assign fill = (state == REQ) & mem_ack;
  assign victim = ~valid[0][cap_idx] ? 1'b0 : ~valid[1][cap_idx] ? 1'b1 : lru[cap_idx];
  assign ic_hit = hit;
  assign r_data = way_hit[0] ? data_mem[0][idx] : data_mem[1][idx];
  assign ic_miss = (state != IDLE) | (ren & ~ic_exp & ~hit & ~flush);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid[0] <= '0;
      valid[1] <= '0;
      lru      <= '0;
      discard  <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      if (hit) lru[idx] <= way_hit[0];
      if (launch) begin
        mem_req  <= 1'b1;
        mem_addr <= 32'({tag, idx, {OFF_W{1'b0}}});
        discard  <= 1'b0;
      end
      if (state == REQ && flush) discard <= 1'b1;
      // a flush seen at any point of the outstanding fill lands the line invalid
      if (fill) begin
        valid[victim][cap_idx] <= ~(discard | flush);
        lru[cap_idx]           <= ~victim;
        mem_req                <= 1'b0;
      end
      state <= launch ? REQ : fill ? FILL : (state == FILL) ? IDLE : state;
      if (flush) begin
        valid[0] <= '0;
        valid[1] <= '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (launch) begin
      cap_tag <= tag;
      cap_idx <= idx;
    end
    if (fill & ~rst) begin
      tag_mem[victim][cap_idx]  <= cap_tag;
      data_mem[victim][cap_idx] <= mem_data;
    end
  end
endmodule

// File: tb/tb_i_cache_2way.sv
// tb_i_cache_2way: directed test of the default cache and a SETS=4/LINE_W=128 instance against a line-level model
module tb_i_cache_2way;
  localparam int L1 = 128;
  localparam int S1 = 4;
  logic clk = 1'b0;
  logic [1:0] rst, ren, ic_exp, flush, mem_ack, hit_o, miss_o, mreq_o;
  logic [14:0] addr [2];
  logic [255:0] mem_data [2];
  logic [255:0] rd0;
  logic [L1-1:0] rd1;
  logic [31:0] ma0, ma1;
  int total = 0;
  int bad = 0;
  int offw [2] = '{$clog2(256 / 8), $clog2(L1 / 8)};
  int idxw [2] = '{$clog2(16), $clog2(S1)};
  bit mv [2][2][16];
  int mt [2][2][16];
  logic [255:0] md [2][2][16];
  bit ml [2][16];
  int ph [2] = '{0, 0};
  bit disc [2];
  bit mreq [2];
  logic [31:0] maddr [2];
  int ctag [2];
  int cidx [2];
  bit armed [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  i_cache_2way dut0 (
    .clk(clk), .rst(rst[0]), .ren(ren[0]), .addr(addr[0]), .ic_exp(ic_exp[0]), .flush(flush[0]),
    .r_data(rd0), .ic_hit(hit_o[0]), .ic_miss(miss_o[0]), .mem_req(mreq_o[0]), .mem_addr(ma0),
    .mem_ack(mem_ack[0]), .mem_data(mem_data[0])
  );
  i_cache_2way #(.ADDR_W(15), .LINE_W(L1), .SETS(S1)) dut1 (
    .clk(clk), .rst(rst[1]), .ren(ren[1]), .addr(addr[1]), .ic_exp(ic_exp[1]), .flush(flush[1]),
    .r_data(rd1), .ic_hit(hit_o[1]), .ic_miss(miss_o[1]), .mem_req(mreq_o[1]), .mem_addr(ma1),
    .mem_ack(mem_ack[1]), .mem_data(mem_data[1][L1-1:0])
  );

  function automatic logic [255:0] msk(int d);
    return d == 0 ? {256{1'b1}} : {{(256 - L1){1'b0}}, {L1{1'b1}}};
  endfunction
  function automatic logic [255:0] rdata(int d);
    return d == 0 ? rd0 : {{(256 - L1){1'b0}}, rd1};
  endfunction
  function automatic logic [31:0] maddr_o(int d);
    return d == 0 ? ma0 : ma1;
  endfunction
  function automatic int idx_of(int d);
    return (int'(addr[d]) >> offw[d]) & ((1 << idxw[d]) - 1);
  endfunction
  function automatic int tag_of(int d);
    return int'(addr[d]) >> (offw[d] + idxw[d]);
  endfunction
  function automatic bit way_match(int d, int w);
    return mv[d][w][idx_of(d)] && mt[d][w][idx_of(d)] == tag_of(d);
  endfunction
  function automatic bit exp_hit(int d);
    return ren[d] && !ic_exp[d] && ph[d] == 0 && !flush[d] && (way_match(d, 0) || way_match(d, 1));
  endfunction
  function automatic bit exp_miss(int d);
    return ph[d] != 0 || (ren[d] && !ic_exp[d] && !exp_hit(d) && !flush[d]);
  endfunction
  function automatic int vic(int d);
    return !mv[d][0][cidx[d]] ? 0 : !mv[d][1][cidx[d]] ? 1 : int'(ml[d][cidx[d]]);
  endfunction
  function automatic logic [31:0] line_addr(int d);
    return (32'(addr[d]) >> offw[d]) << offw[d];
  endfunction

  task automatic cmp1(input int d, input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL d%0d %s got=%b want=%b t=%0t", d, nm, act, exp, $time);
    end
  endtask
  task automatic cmpw(input int d, input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL d%0d %s got=%h want=%h t=%0t", d, nm, act, exp, $time);
    end
  endtask

  // model: lines, LRU and the miss handshake, advanced once per rising edge
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        ph[d]    <= 0;
        mreq[d]  <= 1'b0;
        maddr[d] <= '0;
        disc[d]  <= 1'b0;
        armed[d] <= 1'b1;
        for (int s = 0; s < 16; s++) begin
          mv[d][0][s] <= 1'b0;
          mv[d][1][s] <= 1'b0;
          ml[d][s]    <= 1'b0;
        end
      end else begin
        if (ph[d] == 0) begin
          if (exp_hit(d)) ml[d][idx_of(d)] <= way_match(d, 0);
          else if (ren[d] && !ic_exp[d] && !flush[d]) begin
            ctag[d]  <= tag_of(d);
            cidx[d]  <= idx_of(d);
            mreq[d]  <= 1'b1;
            maddr[d] <= line_addr(d);
            disc[d]  <= 1'b0;
            ph[d]    <= 1;
          end
        end else if (ph[d] == 1) begin
          if (flush[d]) disc[d] <= 1'b1;
          if (mem_ack[d]) begin
            mt[d][vic(d)][cidx[d]] <= ctag[d];
            md[d][vic(d)][cidx[d]] <= mem_data[d] & msk(d);
            mv[d][vic(d)][cidx[d]] <= !(disc[d] || flush[d]);
            ml[d][cidx[d]]         <= vic(d) == 0;
            mreq[d]                <= 1'b0;
            ph[d]                  <= 2;
          end
        end else ph[d] <= 0;
        if (flush[d])
          for (int s = 0; s < 16; s++) begin
            mv[d][0][s] <= 1'b0;
            mv[d][1][s] <= 1'b0;
          end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (armed[d]) begin
        cmp1(d, "m_hit", hit_o[d], exp_hit(d));
        cmp1(d, "m_miss", miss_o[d], exp_miss(d));
        cmp1(d, "m_mem_req", mreq_o[d], mreq[d]);
        if (exp_hit(d)) cmpw(d, "m_r_data", rdata(d), md[d][way_match(d, 0) ? 0 : 1][idx_of(d)]);
        if (mreq[d]) cmpw(d, "m_mem_addr", 256'(maddr_o(d)), 256'(maddr[d]));
      end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    tick();
    rst[d] = 1'b0;
  endtask

  task automatic wait_req(input int d, input string nm);
    int n = 0;
    while (!mreq_o[d] && n < 8) begin
      @(negedge clk);
      n++;
    end
    cmp1(d, {nm, "_req"}, mreq_o[d], 1'b1);
  endtask

  task automatic fill(input int d, input logic [14:0] a, input logic [31:0] ea, input logic [255:0] v, input string nm);
    ren[d] = 1'b1;
    addr[d] = a;
    @(negedge clk);
    cmp1(d, {nm, "_cold_miss"}, miss_o[d], 1'b1);
    wait_req(d, nm);
    cmpw(d, {nm, "_mem_addr"}, 256'(maddr_o(d)), 256'(ea));
    tick();
    mem_data[d] = v;
    mem_ack[d] = 1'b1;
    tick();
    mem_ack[d] = 1'b0;
    @(negedge clk);
    cmp1(d, {nm, "_fill_stall"}, miss_o[d], 1'b1);
    cmp1(d, {nm, "_req_drop"}, mreq_o[d], 1'b0);
    tick();
    @(negedge clk);
    cmp1(d, {nm, "_hit"}, hit_o[d], 1'b1);
    cmpw(d, {nm, "_data"}, rdata(d), v & msk(d));
    #1 ren[d] = 1'b0;
    tick();
  endtask

  // looks a line up without letting the lookup reach a clock edge
  task automatic probe(input int d, input logic [14:0] a, input bit eh, input logic [255:0] ed, input string nm);
    ren[d] = 1'b1;
    addr[d] = a;
    @(negedge clk);
    cmp1(d, {nm, "_hit"}, hit_o[d], eh);
    if (eh) cmpw(d, {nm, "_data"}, rdata(d), ed & msk(d));
    else cmp1(d, {nm, "_miss"}, miss_o[d], 1'b1);
    #1 ren[d] = 1'b0;
    tick();
  endtask

  logic [255:0] pa, pb, pc, pd, pe, pf, pp, pq, pr;

  initial begin
    pa = {8{32'hA5A5_0001}}; pb = {8{32'hB0B0_0002}}; pc = {8{32'hC3C3_0003}};
    pd = {8{32'hD4D4_0004}}; pe = {8{32'hE5E5_0005}}; pf = {8{32'hF6F6_0006}};
    pp = {8{32'h1111_2222}}; pq = {8{32'h3333_4444}}; pr = {8{32'h5555_6666}};
    rst = 2'b11; ren = '0; ic_exp = '0; flush = '0; mem_ack = '0;
    addr[0] = '0; addr[1] = '0; mem_data[0] = '0; mem_data[1] = '0;
    tick();
    tick();
    rst = 2'b00;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cmp1(d, "rst_hit", hit_o[d], 1'b0);
      cmp1(d, "rst_miss", miss_o[d], 1'b0);
      cmp1(d, "rst_mem_req", mreq_o[d], 1'b0);
      cmpw(d, "rst_mem_addr", 256'(maddr_o(d)), 256'(0));
    end
    tick();
    // cold miss then hit; A lands in way0 of set 2
    fill(0, 15'h1A40, 32'h0000_1A40, pa, "a");
    // B fills the empty way1, C then evicts A through LRU
    fill(0, 15'h0040, 32'h0000_0040, pb, "b");
    fill(0, 15'h2040, 32'h0000_2040, pc, "c");
    probe(0, 15'h0040, 1'b1, pb, "b_again");
    probe(0, 15'h2040, 1'b1, pc, "c_again");
    probe(0, 15'h1A40, 1'b0, '0, "a_evicted");
    probe(0, 15'h005F, 1'b1, pb, "b_offset");
    // a real hit on B makes C the LRU victim for D
    ren[0] = 1'b1;
    addr[0] = 15'h0040;
    @(negedge clk);
    cmp1(0, "b_touch", hit_o[0], 1'b1);
    tick();
    ren[0] = 1'b0;
    fill(0, 15'h4040, 32'h0000_4040, pd, "d");
    probe(0, 15'h2040, 1'b0, '0, "c_evicted");
    probe(0, 15'h0040, 1'b1, pb, "b_kept");
    probe(0, 15'h4040, 1'b1, pd, "d_kept");
    // flush while the fill is outstanding
    ren[0] = 1'b1;
    addr[0] = 15'h0100;
    @(negedge clk);
    wait_req(0, "flush_fill");
    tick();
    ren[0] = 1'b0;
    flush[0] = 1'b1;
    @(negedge clk);
    cmp1(0, "flush_keeps_req", mreq_o[0], 1'b1);
    tick();
    flush[0] = 1'b0;
    mem_data[0] = pe;
    mem_ack[0] = 1'b1;
    tick();
    mem_ack[0] = 1'b0;
    @(negedge clk);
    cmp1(0, "flush_fill_done", mreq_o[0], 1'b0);
    tick();
    probe(0, 15'h0100, 1'b0, '0, "discarded");
    probe(0, 15'h0040, 1'b0, '0, "b_flushed");
    probe(0, 15'h4040, 1'b0, '0, "d_flushed");
    // exception on a cached line suppresses everything
    fill(0, 15'h0040, 32'h0000_0040, pb, "b_refill");
    ren[0] = 1'b1;
    ic_exp[0] = 1'b1;
    addr[0] = 15'h0040;
    @(negedge clk);
    cmp1(0, "exp_hit", hit_o[0], 1'b0);
    cmp1(0, "exp_miss", miss_o[0], 1'b0);
    tick();
    @(negedge clk);
    cmp1(0, "exp_mem_req", mreq_o[0], 1'b0);
    #1 ren[0] = 1'b0;
    ic_exp[0] = 1'b0;
    tick();
    // reset in REQ, then stray acks
    ren[0] = 1'b1;
    addr[0] = 15'h2040;
    @(negedge clk);
    wait_req(0, "rst_in_req");
    tick();
    ren[0] = 1'b0;
    do_reset(0);
    @(negedge clk);
    cmp1(0, "rst_req_drop", mreq_o[0], 1'b0);
    cmp1(0, "rst_req_idle", miss_o[0], 1'b0);
    tick();
    mem_data[0] = pf;
    mem_ack[0] = 1'b1;
    tick();
    mem_ack[0] = 1'b0;
    probe(0, 15'h2040, 1'b0, '0, "stray_ack0");
    fill(0, 15'h0040, 32'h0000_0040, pb, "b_post_rst");
    mem_data[0] = pf;
    mem_ack[0] = 1'b1;
    tick();
    mem_ack[0] = 1'b0;
    @(negedge clk);
    cmp1(0, "stray_no_req", mreq_o[0], 1'b0);
    cmp1(0, "stray_no_stall", miss_o[0], 1'b0);
    tick();
    probe(0, 15'h0040, 1'b1, pb, "stray_ack1");
    // SETS=4, LINE_W=128: index addr[5:4], tag addr[14:6]
    fill(1, 15'h0123, 32'h0000_0120, pp, "p");
    probe(1, 15'h012F, 1'b1, pp, "p_offset");
    probe(1, 15'h0113, 1'b0, '0, "other_set");
    fill(1, 15'h0163, 32'h0000_0160, pq, "q");
    probe(1, 15'h0123, 1'b1, pp, "p_alias");
    fill(1, 15'h01A3, 32'h0000_01A0, pr, "r");
    probe(1, 15'h0123, 1'b0, '0, "p_evicted");
    probe(1, 15'h0163, 1'b1, pq, "q_kept");
    probe(1, 15'h01AC, 1'b1, pr, "r_offset");
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
